// File: rtl/isqrt_pipe.sv
// rtl/isqrt_pipe.sv - pipelined floor(sqrt(x)) for a 32-bit operand, 16-bit root
module isqrt_pipe #(
   parameter int N_STAGES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        x_vld,
   input  logic [31:0] x,
   output logic        y_vld,
   output logic [15:0] y
);

   localparam int ITERS = 16 / N_STAGES;

   // Only divisors of 16 give a whole number of iterations per stage.
   if (!(N_STAGES == 1 || N_STAGES == 2 || N_STAGES == 4 ||
         N_STAGES == 8 || N_STAGES == 16)) begin : g_bad_n_stages
      $error("isqrt_pipe: N_STAGES must be 1, 2, 4, 8 or 16");
   end

   // Inter-stage buses: index s is the input of stage s, index N_STAGES the output.
   // The final remainder and the exhausted operand are never carried out of the last stage.
   logic [N_STAGES:0]              vld_c;
   logic [N_STAGES:0][15:0]        root_c;
   logic [N_STAGES-1:0][17:0]      rem_c;
   logic [N_STAGES-1:0][31:0]      xs_c;

   assign vld_c[0]  = x_vld;
   assign root_c[0] = '0;
   assign rem_c[0]  = '0;
   assign xs_c[0]   = x;

   for (genvar s = 0; s < N_STAGES; s++) begin : g_stage
      logic [17:0] rem_d;
      logic [15:0] root_d;
      logic [31:0] xs_d;
      logic [17:0] trial;

      // ITERS restoring bit-pair iterations, consuming operand bits from the top down
      always_comb begin
         rem_d  = rem_c[s];
         root_d = root_c[s];
         xs_d   = xs_c[s];
         trial  = '0;
         for (int i = 0; i < ITERS; i++) begin
            rem_d = {rem_d[15:0], xs_d[31:30]};
            xs_d  = {xs_d[29:0], 2'b00};
            trial = {root_d, 2'b01};
            if (rem_d >= trial) begin
               rem_d  = rem_d - trial;
               root_d = {root_d[14:0], 1'b1};
            end else begin
               root_d = {root_d[14:0], 1'b0};
            end
         end
      end

      if (s < N_STAGES - 1) begin : g_mid
         logic        vld_q;
         logic [15:0] root_q;
         logic [17:0] rem_q;
         logic [31:0] xs_q;

         // Valid always advances; data loads only behind a valid so idle cycles hold state
         always_ff @(posedge clk) begin
            if (rst) begin
               vld_q  <= 1'b0;
               root_q <= '0;
               rem_q  <= '0;
               xs_q   <= '0;
            end else begin
               vld_q <= vld_c[s];
               if (vld_c[s]) begin
                  root_q <= root_d;
                  rem_q  <= rem_d;
                  xs_q   <= xs_d;
               end
            end
         end

         assign vld_c[s+1]  = vld_q;
         assign root_c[s+1] = root_q;
         assign rem_c[s+1]  = rem_q;
         assign xs_c[s+1]   = xs_q;
      end else begin : g_last
         logic        vld_q;
         logic [15:0] root_q;

         // Output stage keeps only the root, which y presents and holds between results
         always_ff @(posedge clk) begin
            if (rst) begin
               vld_q  <= 1'b0;
               root_q <= '0;
            end else begin
               vld_q <= vld_c[s];
               if (vld_c[s]) begin
                  root_q <= root_d;
               end
            end
         end

         assign vld_c[s+1]  = vld_q;
         assign root_c[s+1] = root_q;
      end
   end

   assign y_vld = vld_c[N_STAGES];
   assign y     = root_c[N_STAGES];

endmodule

// File: tb/tb_isqrt_pipe.sv
// tb/tb_isqrt_pipe.sv - scoreboard bench for isqrt_pipe across all legal depths
module tb_isqrt_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        x_vld = 1'b0;
   logic [31:0] x = '0;
   logic        done = 1'b0;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   always #5 clk = ~clk;

   // Reference: largest r with r*r <= v, found by binary search
   function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
      longint lo, hi, mid, vv;
      vv = longint'(v);
      lo = 0;
      hi = 65535;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid * mid <= vv) lo = mid;
         else hi = mid - 1;
      end
      return 16'(lo);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 5; g++) begin : g_dut
      localparam int N = 1 << g;
      logic        yv;
      logic [15:0] yy;
      logic [15:0] exp_q[$];
      int          iss_q[$];
      logic [15:0] last = '0;
      logic        started = 1'b0;

      isqrt_pipe #(.N_STAGES(N)) u_dut (
         .clk   (clk),
         .rst   (rst),
         .x_vld (x_vld),
         .x     (x),
         .y_vld (yv),
         .y     (yy)
      );

      // Issue side: record what the bench drove into this instance
      always @(posedge clk) begin
         if (rst) begin
            exp_q.delete();
            iss_q.delete();
            last    = '0;
            started = 1'b1;
         end else if (x_vld) begin
            exp_q.push_back(ref_sqrt(x));
            iss_q.push_back(cyc + 1);
         end
      end

      // Monitor: compare every presented result, and hold value otherwise
      always @(negedge clk) begin
         if (started) begin
            if (yv) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL spurious_y n=%0d got y=%0h with no pending operand", N, yy);
               end else begin
                  logic [15:0] e;
                  int          t;
                  e = exp_q.pop_front();
                  t = iss_q.pop_front();
                  if (yy !== e) begin
                     errors++;
                     $display("FAIL result n=%0d got y=%0h want %0h", N, yy, e);
                  end
                  checks++;
                  if (cyc - t != N - 1) begin
                     errors++;
                     $display("FAIL latency n=%0d got %0d want %0d", N, cyc - t + 1, N);
                  end
                  last = e;
               end
            end else begin
               checks++;
               if (yy !== last) begin
                  errors++;
                  $display("FAIL hold n=%0d got y=%0h want %0h", N, yy, last);
               end
            end
         end
      end

      // Every accepted operand must have come out by the end of the run
      initial begin
         wait (done);
         checks++;
         if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing n=%0d got %0d outstanding want 0", N, exp_q.size());
         end
      end
   end

   task automatic drive(input logic v, input logic [31:0] d);
      @(posedge clk);
      #2;
      x_vld = v;
      x     = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, $urandom);
   endtask

   logic [31:0] single_tab [8] = '{32'd0, 32'd1, 32'd2, 32'd15, 32'd16, 32'd17,
                                   32'hFFFE_0001, 32'hFFFF_FFFF};
   logic        bub_v [6]      = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   logic [31:0] bub_x [6]      = '{32'd100, 32'd7, 32'd144, 32'd1_000_000, 32'd7, 32'h4000_0000};

   initial begin
      int          got;
      int          sum;
      int          budget;

      // Reset, checking the outputs are cleared while held
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (g_dut[2].yv !== 1'b0 || g_dut[2].yy !== 16'h0) begin
         errors++;
         $display("FAIL reset_state got y_vld=%b y=%0h want 0 0", g_dut[2].yv, g_dut[2].yy);
      end
      rst = 1'b0;

      // Single operands separated by gaps
      foreach (single_tab[i]) begin
         drive(1'b1, single_tab[i]);
         idle(6);
      end

      // Back-to-back squares
      drive(1'b1, 32'd9);
      drive(1'b1, 32'd16);
      drive(1'b1, 32'd25);
      idle(20);

      // Bubble pattern with changing operand during gaps
      foreach (bub_v[i]) drive(bub_v[i], bub_x[i]);
      idle(20);

      // Reset while operands are in flight, with x_vld asserted during reset
      drive(1'b1, 32'd1000);
      drive(1'b1, 32'd2000);
      drive(1'b1, 32'd3000);
      drive(1'b0, 32'd5);
      @(posedge clk);
      #2;
      rst   = 1'b1;
      x_vld = 1'b1;
      x     = 32'd123456;
      @(posedge clk);
      #2;
      rst   = 1'b0;
      x_vld = 1'b1;
      x     = 32'd49;
      idle(20);

      // Three requests summed as a formula would: sqrt16 + sqrt25 + sqrt36
      drive(1'b1, 32'd16);
      drive(1'b1, 32'd25);
      drive(1'b1, 32'd36);
      drive(1'b0, 32'd0);
      got    = 0;
      sum    = 0;
      budget = 0;
      while (got < 3 && budget < 50) begin
         @(negedge clk);
         if (g_dut[2].yv) begin
            got++;
            sum += int'(g_dut[2].yy);
         end
         budget++;
      end
      checks++;
      if (got != 3 || sum != 15) begin
         errors++;
         $display("FAIL formula got %0d responses sum %0d want 3 responses sum 15", got, sum);
      end
      idle(10);

      // Corners and a long random back-to-back stream
      drive(1'b1, 32'd0);
      drive(1'b1, 32'd1);
      drive(1'b1, 32'hFFFF_FFFF);
      for (int i = 0; i < 10000; i++) drive(1'b1, $urandom);
      // Random gaps
      for (int i = 0; i < 500; i++) drive(1'($urandom_range(0, 1)), $urandom);
      idle(40);

      done = 1'b1;
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/isqrt_pipe.md
# isqrt_pipe

Pipelined unsigned integer square root: computes floor(sqrt(x)) for a 32-bit operand and returns a 16-bit root after a fixed latency of `N_STAGES` cycles. It accepts a new operand every cycle with no backpressure, so a formula FSM can issue several square-root requests back to back and collect the results in issue order. It sits between such an FSM's `isqrt_x`/`isqrt_x_vld` outputs and its `isqrt_y`/`isqrt_y_vld` inputs, inside the formula top level.

## Interface
- `N_STAGES`, default 4: number of pipeline register stages, which is also the latency in cycles. Legal values are 1, 2, 4, 8 and 16. Any other value is an elaboration error.
- `clk`  input  1: the only clock; all logic is clocked on the rising edge.
- `rst`  input  1: reset, synchronous and active-high.
- `x_vld`  input  1: qualifies `x` in the current cycle.
- `x`  input  32: unsigned operand.
- `y_vld`  output  1: qualifies `y`; pulses exactly `N_STAGES` cycles after the matching `x_vld`.
- `y`  output  16: unsigned result, floor(sqrt(x)).

## Operation
- Algorithm: digit-by-digit (bit-pair) restoring square root with 16 iterations. For i = 15 down to 0:
  - rem = (rem << 2) | x[2i+1:2i]
  - trial = (root << 2) | 1
  - if rem >= trial: rem = rem − trial, root = (root << 1) | 1
  - else: root = root << 1
  - Initial values: rem = 0, root = 0.
- Widths:
  - rem is 18 bits and trial is 18 bits; neither overflows for any 32-bit input.
  - root is 16 bits.
  - The final remainder is discarded and is not an output.
- Partitioning: each stage is combinational logic for 16/`N_STAGES` iterations followed by a register.
- Per-stage registers:
  - valid bit
  - rem (18 bits)
  - root (16 bits)
  - the not-yet-consumed high bits of x, shifted left by 2×(iterations per stage)
- Valid bits advance every cycle unconditionally.
- The data registers of a stage load only when that stage's incoming valid is 1; otherwise they hold their value.
- `y` is driven from the last stage's root register, so `y` holds the last result while `y_vld` is 0.
- No flow control: every accepted operand produces exactly one result. The stream order is preserved.
- There is no state machine; control is the valid shift chain only.

## Timing
- Latency: if `x_vld`=1 is sampled at rising edge t, then `y_vld`=1 with the result is visible after edge t+`N_STAGES−1` and is sampled by the consumer at edge t+`N_STAGES`.
  - With `N_STAGES`=1, the result is registered once and appears in the cycle after the input.
- Throughput: one operand per cycle. Back-to-back inputs give back-to-back outputs, and bubbles in the input appear unchanged in the output.
- Reset values: `y_vld`=0 and `y`=0. All stage valid bits are 0 and all stage data registers are 0.
- Reset mid-operation:
  - Any cycle with `rst`=1 clears every valid bit at that edge, so in-flight operands are discarded and produce no `y_vld`.
  - `x_vld` is ignored while `rst`=1.
  - After `rst` deasserts, the first accepted operand returns with the normal latency.
- Operand changes while `x_vld`=0 have no effect on `y`.
- Boundary values:
  - x=0 gives 0.
  - x=0xFFFF_FFFF gives 0xFFFF.
  - Perfect squares give the exact root; non-squares truncate (no rounding).

## Test plan
- Single operands with gaps, `N_STAGES`=4. Drive x = 0, 1, 2, 15, 16, 17, 0xFFFE_0001, 0xFFFF_FFFF. Required: y = 0, 1, 1, 3, 4, 4, 0xFFFF, 0xFFFF, each with `y_vld` exactly 4 cycles after its input.
- Back-to-back stream. Drive x = 9, 16, 25 on three consecutive cycles. Required: y = 3, 4, 5 on three consecutive `y_vld` cycles, starting 4 cycles after the first input.
- Bubble pattern. Drive `x_vld` = 1,0,1,1,0,1 with x = 100, 7, 144, 1_000_000, 7, 2^30. Required: `y_vld` shows the pattern 1,0,1,1,0,1 delayed by `N_STAGES`, with y = 10, 12, 1000, 32768. `y` holds its last value during the gaps.
- Reset in flight. Issue 3 operands, assert `rst` for 1 cycle two cycles later, then issue x = 49. Required: none of the first 3 results appears, and y = 7 appears `N_STAGES` cycles after the x = 49 input. After reset, `y`=0 and `y_vld`=0.
- Parameter sweep. For `N_STAGES` = 1, 2, 8, 16, run 10 000 random operands back to back plus the corner cases 0, 1, 0xFFFF_FFFF. Required: every result equals the reference floor(sqrt(x)) and latency equals `N_STAGES`.
- Integration with the formula FSM. Drive a=16, b=25, c=36 into the formula top level. Required: result = 4+5+6 = 15, with exactly three requests and three responses on the square-root interface.
